// File: rtl/alu_operand_b_stage.sv
// Registered ALU B-operand select with valid/ready handshake and internal immediate variants.
// Optional build macro ALU_OPERAND_B_STICKY_ERR_EN makes sel_err sticky until reset.
module alu_operand_b_stage #(
    parameter int                 WIDTH     = 32,
    parameter int                 IMM_WIDTH = 16,
    parameter int                 NUM_EXT   = 2,
    parameter logic [WIDTH-1:0]   CONST_VAL = WIDTH'(32'd4)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [2:0]                                    sel,
    input  logic [WIDTH-1:0]                              b_in,
    input  logic [IMM_WIDTH-1:0]                          imm_in,
    input  logic [((NUM_EXT > 0) ? NUM_EXT : 1)*WIDTH-1:0] ext_in,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [WIDTH-1:0]                              data_out,
    output logic                                          sel_err
);

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] imm_upper;
    logic [WIDTH-1:0] ext0;
    logic [WIDTH-1:0] ext1;
    logic [WIDTH-1:0] sel_value;
    logic             sel_legal;
    logic             accept;
    logic             err_on_accept;
    logic             err_on_drain;

    assign imm_sext  = {{(WIDTH-IMM_WIDTH){imm_in[IMM_WIDTH-1]}}, imm_in};
    assign imm_zext  = {{(WIDTH-IMM_WIDTH){1'b0}}, imm_in};
    assign imm_upper = {imm_in, {(WIDTH-IMM_WIDTH){1'b0}}};

    // Absent channels read as zero so the select mux never slices past ext_in.
    generate
        if (NUM_EXT >= 1) begin : g_ext0
            assign ext0 = ext_in[0 +: WIDTH];
        end else begin : g_no_ext0
            assign ext0 = '0;
        end
        if (NUM_EXT >= 2) begin : g_ext1
            assign ext1 = ext_in[WIDTH +: WIDTH];
        end else begin : g_no_ext1
            assign ext1 = '0;
        end
    endgenerate

    assign sel_legal = (sel < 3'd6)
                    || ((sel == 3'd6) && (NUM_EXT >= 1))
                    || ((sel == 3'd7) && (NUM_EXT >= 2));

    always_comb begin
        sel_value = '0;
        case (sel)
            3'd0:    sel_value = b_in;
            3'd1:    sel_value = CONST_VAL;
            3'd2:    sel_value = imm_sext;
            3'd3:    sel_value = imm_sext << 2;
            3'd4:    sel_value = imm_zext;
            3'd5:    sel_value = imm_upper;
            3'd6:    sel_value = ext0;
            default: sel_value = ext1;
        endcase
    end

    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;

`ifdef ALU_OPERAND_B_STICKY_ERR_EN
    assign err_on_accept = sel_err | ~sel_legal;
    assign err_on_drain  = sel_err;
`else
    assign err_on_accept = ~sel_legal;
    assign err_on_drain  = 1'b0;
`endif

    // A stalled result (out_valid && !out_ready) falls through every branch and is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sel_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            data_out  <= sel_legal ? sel_value : '0;
            sel_err   <= err_on_accept;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            sel_err   <= err_on_drain;
        end
    end

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Scoreboard bench for alu_operand_b_stage: one instance with two external channels, one with a single channel.
module tb_alu_operand_b_stage;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  sel = '0;
    logic [31:0] b_in = '0;
    logic [15:0] imm_in = '0;
    logic [63:0] ext_in = '0;
    logic        req_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        req_ready2, out_valid2, sel_err2;
    logic [31:0] data_out2;
    logic        req_ready1, out_valid1, sel_err1;
    logic [31:0] data_out1;

    int          tests = 0;
    int          fails = 0;
    exp_t        q2[$];
    exp_t        q1[$];
    logic        mvalid = 1'b0;
    logic        sticky = 1'b0;

    always #5 clk = ~clk;

    alu_operand_b_stage #(.WIDTH(32), .IMM_WIDTH(16), .NUM_EXT(2), .CONST_VAL(32'd4)) dut2 (
        .clk(clk), .reset(reset), .sel(sel), .b_in(b_in), .imm_in(imm_in), .ext_in(ext_in),
        .req_valid(req_valid), .req_ready(req_ready2), .out_valid(out_valid2),
        .out_ready(out_ready), .data_out(data_out2), .sel_err(sel_err2)
    );

    alu_operand_b_stage #(.WIDTH(32), .IMM_WIDTH(16), .NUM_EXT(1), .CONST_VAL(32'd4)) dut1 (
        .clk(clk), .reset(reset), .sel(sel), .b_in(b_in), .imm_in(imm_in), .ext_in(ext_in[31:0]),
        .req_valid(req_valid), .req_ready(req_ready1), .out_valid(out_valid1),
        .out_ready(out_ready), .data_out(data_out1), .sel_err(sel_err1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the bench's own handshake model decides acceptance and queues expectations.
    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [31:0] b,
                                 input logic rdy, input logic [31:0] e2, input logic [31:0] e1,
                                 input logic ill1);
        logic ready_model;
        logic acc;
        logic next_valid;
        exp_t item;
        req_valid = v;
        sel       = s;
        b_in      = b;
        out_ready = rdy;
        #1;
        ready_model = !mvalid || rdy;
        checkOutput("req_ready2", {31'd0, req_ready2}, {31'd0, ready_model});
        checkOutput("req_ready1", {31'd0, req_ready1}, {31'd0, ready_model});
        acc = v && ready_model;
        if (acc) begin
            item.data = e2;
            item.err  = 1'b0;
            q2.push_back(item);
            sticky = sticky | ill1;
            item.data = e1;
`ifdef ALU_OPERAND_B_STICKY_ERR_EN
            item.err  = sticky;
`else
            item.err  = ill1;
`endif
            q1.push_back(item);
        end
        next_valid = acc || (mvalid && !rdy);
        @(posedge clk);
        #1;
        mvalid = next_valid;
        if (acc) begin
            checkOutput("latency_valid2", {31'd0, out_valid2}, 32'd1);
            checkOutput("latency_valid1", {31'd0, out_valid1}, 32'd1);
        end
    endtask

    // Monitors: a result is retired on every cycle where it is presented and taken.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid2 && out_ready) begin
            if (q2.size() == 0) begin
                checkOutput("unexpected_out2", data_out2, 32'hXXXXXXXX);
            end else begin
                e = q2.pop_front();
                checkOutput("data_out2", data_out2, e.data);
                checkOutput("sel_err2", {31'd0, sel_err2}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checkOutput("unexpected_out1", data_out1, 32'hXXXXXXXX);
            end else begin
                e = q1.pop_front();
                checkOutput("data_out1", data_out1, e.data);
                checkOutput("sel_err1", {31'd0, sel_err1}, {31'd0, e.err});
            end
        end
    end

    initial begin
        logic [31:0] sweep_exp [6];
        sweep_exp[0] = 32'h12345678;
        sweep_exp[1] = 32'h00000004;
        sweep_exp[2] = 32'hFFFFFFFE;
        sweep_exp[3] = 32'hFFFFFFF8;
        sweep_exp[4] = 32'h0000FFFE;
        sweep_exp[5] = 32'hFFFE0000;
        ext_in = {32'hBBBB0000, 32'h0000AAAA};

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, out_valid2}, 32'd0);
        checkOutput("reset_data", data_out2, 32'd0);
        checkOutput("reset_err", {31'd0, sel_err1}, 32'd0);
        reset = 1'b0;

        // Source sweep.
        imm_in = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 3'(i), 32'h12345678, 1'b1, sweep_exp[i], sweep_exp[i], 1'b0);
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // Back-pressure with changing inputs, then a no-bubble reload.
        applyStimulus(1'b1, 3'd0, 32'hA, 1'b1, 32'hA, 32'hA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'(i + 2), 32'h55 + 32'(i), 1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput("hold_data2", data_out2, 32'hA);
            checkOutput("hold_valid1", {31'd0, out_valid1}, 32'd1);
        end
        applyStimulus(1'b1, 3'd0, 32'hB, 1'b1, 32'hB, 32'hB, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // Illegal code on the single-channel instance, then a legal follow-up.
        applyStimulus(1'b1, 3'd7, 32'h0, 1'b1, 32'hBBBB0000, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'd0, 32'hC0DE, 1'b1, 32'hC0DE, 32'hC0DE, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // External channels back to back.
        applyStimulus(1'b1, 3'd6, 32'h0, 1'b1, 32'h0000AAAA, 32'h0000AAAA, 1'b0);
        applyStimulus(1'b1, 3'd7, 32'h0, 1'b1, 32'hBBBB0000, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset while an illegal result is stalled.
        applyStimulus(1'b1, 3'd7, 32'h0, 1'b0, 32'hBBBB0000, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("stall_err1", {31'd0, sel_err1}, 32'd1);
        checkOutput("stall_data2", data_out2, 32'hBBBB0000);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_valid2", {31'd0, out_valid2}, 32'd0);
        checkOutput("async_data2", data_out2, 32'd0);
        checkOutput("async_valid1", {31'd0, out_valid1}, 32'd0);
        checkOutput("async_err1", {31'd0, sel_err1}, 32'd0);
        q1.delete();
        q2.delete();
        mvalid = 1'b0;
        sticky = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("post_reset_ready2", {31'd0, req_ready2}, 32'd1);
        checkOutput("post_reset_ready1", {31'd0, req_ready1}, 32'd1);
        applyStimulus(1'b1, 3'd1, 32'h0, 1'b1, 32'h4, 32'h4, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        checkOutput("q2_drained", 32'(q2.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_b_stage.md
# alu_operand_b_stage

Parametrised, registered successor to the ALU B-operand select, placed between the register-file/immediate path and the ALU B input of the multi-cycle datapath. It selects one of eight operand sources, builds immediate variants internally (sign/zero extend, branch offset shift, upper-immediate), and holds the result in an output register with a valid/ready handshake. The control FSM can issue a new operand every cycle, and the ALU can stall it.

## Interface
Parameters:
- WIDTH, 32, operand width
- IMM_WIDTH, 16, raw immediate width; must satisfy 1 <= IMM_WIDTH <= WIDTH-2
- NUM_EXT, 2, external extra channels, 0..2
- CONST_VAL, 32'd4, constant for select code 1 (PC increment)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- sel  in  3  source select code
- b_in  in  WIDTH  register B value
- imm_in  in  IMM_WIDTH  raw instruction immediate
- ext_in  in  max(NUM_EXT,1)*WIDTH  external channels; channel k is bits [k*WIDTH +: WIDTH]
- req_valid  in  1  request present
- req_ready  out  1  stage can accept
- out_valid  out  1  data_out holds a result
- out_ready  in  1  consumer takes the result
- data_out  out  WIDTH  registered operand
- sel_err  out  1  illegal select seen

## Operation
- Select codes:
  - 0: b_in
  - 1: CONST_VAL
  - 2: sign-extend(imm_in)
  - 3: sign-extend(imm_in) << 2, upper bits truncated to WIDTH
  - 4: zero-extend(imm_in)
  - 5: imm_in << (WIDTH-IMM_WIDTH), i.e. upper immediate, low bits zero
  - 6: ext channel 0
  - 7: ext channel 1
- Codes 6+NUM_EXT..7 are illegal.
- Accept condition: req_valid && req_ready.
- req_ready = !out_valid || out_ready. It is combinational and has no dependence on req_valid.
- On accept:
  - data_out <= selected value; out_valid <= 1.
  - For an illegal code, data_out <= 0, out_valid <= 1, sel_err is raised (see Configuration).
- out_valid && out_ready && no accept: out_valid <= 0. data_out keeps its last value.
- out_valid && !out_ready: data_out and out_valid are held stable. Input changes are ignored.
- Simultaneous drain and accept: the new value is loaded and out_valid stays 1. There is no bubble.
- All arithmetic is unsigned bit manipulation. No overflow flag is produced.

## Timing
- Reset values: out_valid=0, data_out=0, sel_err=0. Reset is asynchronous, takes effect immediately, and discards any pending result.
- Latency: 1 cycle from accept edge to out_valid/data_out visible.
- Throughput: 1 operand per cycle while out_ready=1.
- Back-pressure: with out_valid=1 and out_ready=0, req_ready is 0 in the same cycle.
- First cycle after reset deassertion: req_ready=1.

## Configuration
- Macro: ALU_OPERAND_B_STICKY_ERR_EN.
- Defined: sel_err is sticky. It is set on the first accepted illegal code and stays 1 until reset.
- Undefined: sel_err is a one-cycle registered pulse. It is 1 exactly in the cycle out_valid presents that illegal result's zero data, and 0 otherwise.
- Data path and handshake behaviour are identical in both builds.

## Test plan
- Reset mid-stall: reset=1 asynchronously while out_valid=1 and out_ready=0 -> out_valid=0, data_out=0, sel_err=0 before the next edge; req_ready=1 after release.
- Source sweep (WIDTH=32, IMM_WIDTH=16), imm_in=16'hFFFE, b_in=32'h12345678, out_ready=1, sel 0..5:
  - sel 0 -> 32'h12345678
  - sel 1 -> 32'h4
  - sel 2 -> 32'hFFFFFFFE
  - sel 3 -> 32'hFFFFFFF8
  - sel 4 -> 32'h0000FFFE
  - sel 5 -> 32'hFFFE0000
  - Each result appears one cycle after accept.
- Back-pressure: accept sel=0 with b_in=32'hA, hold out_ready=0 for 3 cycles while sel/b_in change -> data_out stays 32'hA, req_ready=0; then out_ready=1 with a new request -> next value loads with no bubble cycle.
- Illegal code (NUM_EXT=1): sel=7 accepted -> data_out=0, out_valid=1, sel_err=1.
  - Next legal accept, without ALU_OPERAND_B_STICKY_ERR_EN -> sel_err=0.
  - Next legal accept, with ALU_OPERAND_B_STICKY_ERR_EN -> sel_err=1 until reset.
- External channels (NUM_EXT=2): ext_in={32'hBBBB0000, 32'h0000AAAA}, sel=6 then sel=7 on back-to-back cycles -> data_out=32'h0000AAAA, then 32'hBBBB0000, with out_valid continuously 1.
